// File: rtl/reg_wr_pkg.sv
// Shared types and constants for the register writeback arbiter:
// FSM state encoding, strobe bit positions and requester IDs.
package reg_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_ALU = 2'd1,
        ST_WR_LD  = 2'd2
    } state_t;

    // Bit positions inside the 16-bit write strobe.
    localparam logic [3:0] SEL_WORD_BASE = 4'd0;
    localparam logic [3:0] SEL_HIGH_BASE = 4'd8;
    localparam logic [3:0] SEL_LOW_BASE  = 4'd12;

    // Requester IDs as reported on last_grant.
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

endpackage

// File: rtl/reg_write_arbiter_decoder.sv
// Decoder: maps (reg, size, high_low) to a one-hot register-file strobe.
// Ports: reg_idx/size/high_low in; sel (16b one-hot or 0), illegal out.
module Decoder
    import reg_wr_pkg::*;
(
    input  logic [2:0]  reg_idx,
    input  logic        size,
    input  logic        high_low,
    output logic [15:0] sel,
    output logic        illegal
);

    always_comb begin
        sel     = '0;
        illegal = 1'b0;
        unique case (1'b1)
            size:
                sel = 16'h0001 << (SEL_WORD_BASE + {1'b0, reg_idx});
            (!size && reg_idx[2]):
                // Byte registers exist only for AX..DX.
                illegal = 1'b1;
            (!size && !reg_idx[2] && high_low):
                sel = 16'h0001 << (SEL_HIGH_BASE + {2'b00, reg_idx[1:0]});
            default:
                sel = 16'h0001 << (SEL_LOW_BASE + {2'b00, reg_idx[1:0]});
        endcase
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter between ALU and load writeback into the register file.
// Ports: clk/rst; alu_* and ld_* valid/ready requests; rf_stall;
// registered wr_sel/wr_data strobe; last_grant (0 ALU, 1 LD).
// Optional REG_WR_ARB_ERR_EN adds err_illegal pulse and saturating err_cnt.
module reg_write_arbiter
    import reg_wr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [2:0]       alu_reg,
    input  logic             alu_size,
    input  logic             alu_high_low,
    input  logic [15:0]      alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [2:0]       ld_reg,
    input  logic             ld_size,
    input  logic             ld_high_low,
    input  logic [15:0]      ld_data,
    input  logic             rf_stall,
    output logic [15:0]      wr_sel,
    output logic [15:0]      wr_data,
`ifdef REG_WR_ARB_ERR_EN
    output logic             err_illegal,
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic             last_grant
);

    state_t      state_q, state_d;
    logic        last_q;
    logic [15:0] sel_q, data_q;

    logic [15:0] alu_sel, ld_sel;
    logic        alu_ill, ld_ill;

    logic        grant_alu, grant_ld;
    logic        acc_alu, acc_ld, acc_any;
    logic [15:0] sel_mux, data_mux;
    logic        ill_mux;

    Decoder u_dec_alu (
        .reg_idx  (alu_reg),
        .size     (alu_size),
        .high_low (alu_high_low),
        .sel      (alu_sel),
        .illegal  (alu_ill)
    );

    Decoder u_dec_ld (
        .reg_idx  (ld_reg),
        .size     (ld_size),
        .high_low (ld_high_low),
        .sel      (ld_sel),
        .illegal  (ld_ill)
    );

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant_alu = 1'b0;
        grant_ld  = 1'b0;
        if (alu_valid && ld_valid) begin
            if (last_q == REQ_LD) grant_alu = 1'b1;
            else                  grant_ld  = 1'b1;
        end else begin
            grant_alu = alu_valid;
            grant_ld  = ld_valid;
        end
    end

    assign alu_ready = !rst && !rf_stall && grant_alu;
    assign ld_ready  = !rst && !rf_stall && grant_ld;

    assign acc_alu = alu_valid && alu_ready;
    assign acc_ld  = ld_valid && ld_ready;
    assign acc_any = acc_alu || acc_ld;

    always_comb begin
        sel_mux  = alu_sel;
        ill_mux  = alu_ill;
        data_mux = alu_size ? alu_data : {8'h00, alu_data[7:0]};
        if (acc_ld) begin
            sel_mux  = ld_sel;
            ill_mux  = ld_ill;
            data_mux = ld_size ? ld_data : {8'h00, ld_data[7:0]};
        end
    end

    // Illegal byte writes are accepted but never leave IDLE.
    always_comb begin
        state_d = ST_IDLE;
        if (acc_alu && !alu_ill) state_d = ST_WR_ALU;
        else if (acc_ld && !ld_ill) state_d = ST_WR_LD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            last_q  <= REQ_LD;
        end else begin
            state_q <= state_d;
            sel_q   <= (state_d != ST_IDLE) ? sel_mux : '0;
            data_q  <= (state_d != ST_IDLE) ? data_mux : '0;
            if (acc_any) last_q <= acc_ld;
        end
    end

    // Reset masks a strobe already sitting in the output register.
    assign wr_sel     = (rst || state_q == ST_IDLE) ? '0 : sel_q;
    assign wr_data    = (rst || state_q == ST_IDLE) ? '0 : data_q;
    assign last_grant = last_q;

`ifdef REG_WR_ARB_ERR_EN
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= acc_any && ill_mux;
            if (acc_any && ill_mux && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err_illegal = err_q && !rst;
    assign err_cnt     = cnt_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed scenarios then
// random traffic against a behavioural arbitration model.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, alu_size, alu_high_low;
    logic [2:0]  alu_reg;
    logic [15:0] alu_data;
    logic        ld_valid, ld_ready, ld_size, ld_high_low;
    logic [2:0]  ld_reg;
    logic [15:0] ld_data;
    logic        rf_stall;
    logic [15:0] wr_sel, wr_data;
    logic        last_grant;
`ifdef REG_WR_ARB_ERR_EN
    logic        err_illegal;
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    reg_write_arbiter #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_reg      (alu_reg),
        .alu_size     (alu_size),
        .alu_high_low (alu_high_low),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_reg       (ld_reg),
        .ld_size      (ld_size),
        .ld_high_low  (ld_high_low),
        .ld_data      (ld_data),
        .rf_stall     (rf_stall),
        .wr_sel       (wr_sel),
        .wr_data      (wr_data),
`ifdef REG_WR_ARB_ERR_EN
        .err_illegal  (err_illegal),
        .err_cnt      (err_cnt),
`endif
        .last_grant   (last_grant)
    );

    typedef struct {
        logic [15:0] sel;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t sq[$];
    int   eq[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Model state: *_next is decided before an edge, *_now holds after it.
    int m_last_next = 1, m_last_now = 1;
    int m_err_next  = 0, m_err_now  = 0;

    // Stimulus-side request holders.
    bit          a_pend, l_pend, stall_v, rst_v;
    logic [2:0]  a_reg, l_reg;
    logic        a_size, a_hl, l_size, l_hl;
    logic [15:0] a_data, l_data;
    bit          acc_a, acc_l;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Register-file meaning of a request, straight from the register map.
    function automatic void model_wr(input logic [2:0] r, input logic s,
                                     input logic hl, input logic [15:0] d,
                                     output logic [15:0] sel,
                                     output logic [15:0] data,
                                     output bit ill);
        int idx;
        ill  = 0;
        sel  = '0;
        data = '0;
        if (s) begin
            sel  = 16'(1) << int'(r);
            data = d;
        end else if (int'(r) >= 4) begin
            ill = 1;
        end else begin
            idx  = (hl ? 8 : 12) + int'(r);
            sel  = 16'(1) << idx;
            data = {8'h00, d[7:0]};
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_last_now = m_last_next;
        m_err_now  = m_err_next;
    end

    // One cycle: drive at negedge, predict ready and the resulting write.
    task automatic tick();
        bit          ea, el, ill;
        logic [15:0] s, d;
        @(negedge clk);
        rst          = rst_v;
        rf_stall     = stall_v;
        alu_valid    = a_pend;
        alu_reg      = a_reg;
        alu_size     = a_size;
        alu_high_low = a_hl;
        alu_data     = a_data;
        ld_valid     = l_pend;
        ld_reg       = l_reg;
        ld_size      = l_size;
        ld_high_low  = l_hl;
        ld_data      = l_data;
        #1;
        ea = 0;
        el = 0;
        if (!rst_v && !stall_v) begin
            if (a_pend && l_pend) begin
                if (m_last_now == 1) ea = 1;
                else                 el = 1;
            end else begin
                ea = a_pend;
                el = l_pend;
            end
        end
        check("alu_ready", {31'd0, alu_ready}, {31'd0, ea});
        check("ld_ready", {31'd0, ld_ready}, {31'd0, el});
        if (ea) model_wr(a_reg, a_size, a_hl, a_data, s, d, ill);
        if (el) model_wr(l_reg, l_size, l_hl, l_data, s, d, ill);
        if (ea || el) begin
            if (!ill) sq.push_back('{s, d, cyc + 1});
            else begin
                eq.push_back(cyc + 1);
                if (m_err_next < 255) m_err_next++;
            end
            m_last_next = el ? 1 : 0;
        end
        if (rst_v) begin
            m_last_next = 1;
            m_err_next  = 0;
        end
        acc_a = ea;
        acc_l = el;
        if (ea) a_pend = 0;
        if (el) l_pend = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_alu(input logic [2:0] r, input logic s,
                           input logic hl, input logic [15:0] d);
        a_pend = 1; a_reg = r; a_size = s; a_hl = hl; a_data = d;
    endtask

    task automatic set_ld(input logic [2:0] r, input logic s,
                          input logic hl, input logic [15:0] d);
        l_pend = 1; l_reg = r; l_size = s; l_hl = hl; l_data = d;
    endtask

    // Monitor: mid-cycle, after the driver has settled this cycle's inputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] es, ed;
        bit          ee;
        #2;
        es = '0;
        ed = '0;
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
            check("strobe_cycle", sq[0].cyc, cyc);
            void'(sq.pop_front());
        end
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
            e  = sq.pop_front();
            es = e.sel;
            ed = e.data;
        end
        if (rst) begin
            es = '0;
            ed = '0;
        end
        check("wr_sel", {16'd0, wr_sel}, {16'd0, es});
        check("wr_data", {16'd0, wr_data}, {16'd0, ed});
        check("last_grant", {31'd0, last_grant}, 32'(m_last_now));
        ee = 0;
        while (eq.size() > 0 && eq[0] < cyc) void'(eq.pop_front());
        if (eq.size() > 0 && eq[0] == cyc) begin
            void'(eq.pop_front());
            ee = !rst;
        end
`ifdef REG_WR_ARB_ERR_EN
        check("err_illegal", {31'd0, err_illegal}, {31'd0, ee});
        check("err_cnt", {24'd0, err_cnt}, 32'(m_err_now));
`endif
    end

    initial begin
        rst = 1; rf_stall = 0;
        alu_valid = 0; alu_reg = 0; alu_size = 0; alu_high_low = 0;
        alu_data = 0;
        ld_valid = 0; ld_reg = 0; ld_size = 0; ld_high_low = 0; ld_data = 0;
        a_pend = 0; l_pend = 0; stall_v = 0; rst_v = 1;
        a_reg = 0; a_size = 0; a_hl = 0; a_data = 0;
        l_reg = 0; l_size = 0; l_hl = 0; l_data = 0;
        run(3);
        rst_v = 0;
        run(2);

        // Single word write to AX.
        set_alu(3'b000, 1, 0, 16'h1234);
        run(4);

        // Tie after reset: ALU first, then CH via the loader.
        set_alu(3'b001, 1, 0, 16'hBEEF);
        set_ld(3'b010, 0, 1, 16'h5A7C);
        run(4);

        // Sustained contention: alternating grants, no bubbles.
        for (int i = 0; i < 6; i++) begin
            if (!a_pend) set_alu(3'(i), 1, 0, 16'(16'h1100 + i));
            if (!l_pend) set_ld(3'(i + 2), 1, 0, 16'(16'h2200 + i));
            tick();
        end
        a_pend = 0;
        l_pend = 0;
        run(2);

        // Stall holds off a load, then it goes through.
        set_ld(3'b011, 0, 0, 16'h00C3);
        stall_v = 1;
        run(3);
        stall_v = 0;
        run(3);

        // Illegal byte write to a non-byte register.
        set_alu(3'b101, 0, 0, 16'h0077);
        run(3);

        // Saturation of the illegal counter.
        for (int i = 0; i < 300; i++) begin
            set_alu(3'($urandom_range(4, 7)), 0, 1'($urandom),
                    16'($urandom));
            tick();
        end
        run(2);

        // Reset in the cycle right after an acceptance.
        set_ld(3'b110, 1, 0, 16'hCAFE);
        tick();
        rst_v = 1;
        tick();
        rst_v = 0;
        run(3);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (!a_pend && ($urandom % 3 != 0))
                set_alu(3'($urandom), 1'($urandom), 1'($urandom),
                        16'($urandom));
            if (!l_pend && ($urandom % 3 != 0))
                set_ld(3'($urandom), 1'($urandom), 1'($urandom),
                       16'($urandom));
            stall_v = ($urandom % 5 == 0);
            rst_v   = ($urandom % 150 == 0);
            if (rst_v) begin
                a_pend = 0;
                l_pend = 0;
            end
            tick();
        end
        rst_v = 0;
        stall_v = 0;
        a_pend = 0;
        l_pend = 0;
        run(4);
        check("scoreboard_drained", sq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the illegal-request counter.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports alu_valid input 1, alu_ready output 1, alu_reg input 3, alu_size input 1, alu_high_low input 1, alu_data input 16; ALU writeback request.
REQ-005 SHALL have ports ld_valid input 1, ld_ready output 1, ld_reg input 3, ld_size input 1, ld_high_low input 1, ld_data input 16; memory-load writeback request.
REQ-006 SHALL have port rf_stall  input  1  register file cannot accept a write this cycle.
REQ-007 SHALL have port wr_sel  output  16  one-hot write strobe: bits 0-7 AX,BX,CX,DX,SI,DI,SP,BP; 8-11 AH,BH,CH,DH; 12-15 AL,BL,CL,DL.
REQ-008 SHALL have port wr_data  output  16  write data; 8-bit writes on bits 7:0.
REQ-009 SHALL have port last_grant  output  1  requester granted most recently (0 ALU, 1 LD).
REQ-010 SHALL, with REG_WR_ARB_ERR_EN only, have ports err_illegal output 1 and err_cnt output CNT_W.

Function
REQ-011 SHALL implement FSM states IDLE, WR_ALU, WR_LD; state is WR_x for exactly the cycle after x's request is accepted.
REQ-012 SHALL accept a request when valid and ready are both high in the same cycle.
REQ-013 SHALL drive alu_ready/ld_ready combinationally: both low while rf_stall=1; otherwise at most one high.
REQ-014 SHALL grant the sole valid requester; when both valid, grant the one not equal to last_grant (round-robin).
REQ-015 SHALL update last_grant only on acceptance.
REQ-016 SHALL register outputs: wr_sel/wr_data reflect an accepted request exactly one cycle after acceptance, for exactly one cycle.
REQ-017 SHALL drive wr_sel=0 and wr_data=0 in IDLE and in any cycle without a preceding acceptance.
REQ-018 SHALL sustain one acceptance per cycle back-to-back (IDLE skipped when requests continue).
REQ-019 SHALL treat size=0 with reg[2]=1 as illegal: accept it (ready unaffected), produce wr_sel=0, and go to IDLE instead of WR_x.
REQ-020 SHALL ignore high_low when size=1.
REQ-021 SHALL require requesters to hold valid and payload stable until accepted; unaccepted requests are not captured.
REQ-022 SHALL, when rf_stall rises, accept nothing while an already-registered write still presents its single cycle.

Reset
REQ-023 SHALL on rst=1 at a clock edge force state IDLE, wr_sel=0, wr_data=0, last_grant=1 (ALU wins first tie), err_illegal=0, err_cnt=0.
REQ-024 SHALL hold both ready outputs low while rst=1.
REQ-025 SHALL discard a write registered in the cycle reset is applied; no strobe appears after reset.

Configuration
REQ-026 SHALL, with REG_WR_ARB_ERR_EN defined, pulse err_illegal for one cycle after an illegal acceptance and increment err_cnt, saturating at 2^CNT_W-1.
REQ-027 SHALL, without REG_WR_ARB_ERR_EN, omit err_illegal/err_cnt and drop illegal requests silently; all other behaviour identical.

Structure
REQ-028 SHALL place FSM state encoding, the 16-bit strobe bit positions and requester IDs in the shared package reg_wr_pkg.
REQ-029 SHALL compute the strobe via one instance of the existing Decoder module per requester, muxed by grant.

Verification
REQ-030 SHALL cover: reset, alu_valid=1 reg=000 size=1 data=0x1234 -> next cycle wr_sel=0x0001, wr_data=0x1234, one cycle only.
REQ-031 SHALL cover: both valid after reset, ALU reg=001 size=1, LD reg=010 size=0 high_low=1 -> ALU first (wr_sel=0x0002), then LD (wr_sel=0x0400), last_grant 0 then 1.
REQ-032 SHALL cover: both valid continuously 6 cycles -> grants alternate ALU,LD,ALU,... with strobes every cycle, no gaps.
REQ-033 SHALL cover: ld_valid=1 with rf_stall=1 for 3 cycles -> ld_ready=0, wr_sel=0 throughout; stall drops -> accepted, strobe next cycle.
REQ-034 SHALL cover: ALU reg=101 size=0 -> accepted, wr_sel=0; with REG_WR_ARB_ERR_EN err_illegal pulses, err_cnt=1; 300 illegal requests -> err_cnt=255.
REQ-035 SHALL cover: rst asserted the cycle after acceptance -> wr_sel stays 0, last_grant=1.
